// File: rtl/fpu_pkg.sv
// Shared FPU definitions: converter FSM states, rounding modes, IEEE-754 single
// field widths and a leading-zero counter used by the fast normaliser.
package fpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int unsigned BIAS  = 127;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    // Exponent of a 32-bit integer whose MSB sits at bit 31.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + 31);

    function automatic logic [5:0] lzc32(input logic [31:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(31 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fcvt_s_w_if.sv
// Request/response bundle of the integer-to-single converter.
// start is accepted only while busy is low; done pulses one cycle and
// result/inexact stay valid from then until the next accepted start.
interface fcvt_s_w_if;
    logic        start;
    logic [31:0] int_in;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        inexact;

    modport master (
        output start, int_in, is_unsigned, rm,
        input  busy, done, result, inexact
    );

    modport slave (
        input  start, int_in, is_unsigned, rm,
        output busy, done, result, inexact
    );
endinterface

// File: rtl/fpu_round.sv
// Round-increment decision shared by FPU converters; unknown rm codes round
// to nearest-even.
module fpu_round
    import fpu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       increment
);

    always_comb begin
        increment = 1'b0;
        case (rm)
            RM_RTZ:  increment = 1'b0;
            RM_RDN:  increment = sign & (guard | sticky);
            RM_RUP:  increment = ~sign & (guard | sticky);
            RM_RMM:  increment = guard;
            default: increment = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fcvt_s_w.sv
// FCVT.S.W / FCVT.S.WU: 32-bit integer to IEEE-754 single, multi-cycle.
// Define FCVT_FAST_NORM_EN for a single-cycle barrel-shift normaliser.
module fcvt_s_w
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    fcvt_s_w_if.slave  bus,
    output state_e     state_o
);

    state_e             state_q, state_d;
    logic [31:0]        mag_q, mag_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               sign_q, sign_d;
    logic [2:0]         rm_q, rm_d;
    logic [31:0]        result_q, result_d;
    logic               inexact_q, inexact_d;

    logic               round_inc;
    logic [MAN_W:0]     sig_rnd;
    logic [EXP_W-1:0]   exp_rnd;
`ifdef FCVT_FAST_NORM_EN
    logic [5:0]         lz;
    assign lz = lzc32(mag_q);
`endif

    // After NORM the leading one is at bit 31, so it is the hidden bit.
    fpu_round u_round (
        .rm        (rm_q),
        .sign      (sign_q),
        .lsb       (mag_q[8]),
        .guard     (mag_q[7]),
        .sticky    (|mag_q[6:0]),
        .increment (round_inc)
    );

    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign sig_rnd = {1'b0, mag_q[30:8]} + {{MAN_W{1'b0}}, round_inc};
    assign exp_rnd = exp_q + {{(EXP_W-1){1'b0}}, sig_rnd[MAN_W]};

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        rm_d      = rm_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.int_in[31] & ~bus.is_unsigned;
                    mag_d   = (bus.int_in[31] & ~bus.is_unsigned) ? (32'd0 - bus.int_in)
                                                                  : bus.int_in;
                    exp_d   = EXP_INIT;
                    rm_d    = bus.rm;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q == 32'd0) begin
                    result_d  = 32'd0;
                    inexact_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
`ifdef FCVT_FAST_NORM_EN
                    mag_d   = mag_q << lz;
                    exp_d   = exp_q - EXP_W'(lz);
                    state_d = S_ROUND;
`else
                    if (mag_q[31]) begin
                        state_d = S_ROUND;
                    end else begin
                        mag_d = {mag_q[30:0], 1'b0};
                        exp_d = exp_q - 1'b1;
                    end
`endif
                end
            end
            S_ROUND: begin
                result_d  = {sign_q, exp_rnd, sig_rnd[MAN_W-1:0]};
                inexact_d = mag_q[7] | (|mag_q[6:0]);
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mag_q     <= 32'd0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            rm_q      <= 3'd0;
            result_q  <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            rm_q      <= rm_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign bus.inexact = inexact_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fcvt_s_w.sv
// Self-checking bench for fcvt_s_w: directed table, corner sequences and
// random conversions against an arithmetic reference model.
module tb_fcvt_s_w;
    import fpu_pkg::*;

    logic   clk;
    logic   rst;
    state_e state_dbg;
    int     n_tests;
    int     n_fail;
    logic [32:0] exp_q[$];

    fcvt_s_w_if bus();

    fcvt_s_w dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        uns;
        logic [2:0]  rmv;
        logic [31:0] x;
        logic [31:0] exp_res;
        logic        exp_nx;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Reference: exact value, round to 24 significant bits by the rm rule.
    function automatic void ref_model(input logic uns, input logic [2:0] rmv, input logic [31:0] x,
                                      output logic [31:0] res, output logic nx, output int lat);
        longint mag, q, rem, half;
        int     p, shift;
        logic   s, inc;
        s   = x[31] & ~uns;
        mag = longint'({32'd0, x});
        if (s) mag = 64'h1_0000_0000 - mag;
        if (mag == 0) begin
            res = 32'd0; nx = 1'b0; lat = 2;
            return;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
`ifdef FCVT_FAST_NORM_EN
        lat = 3;
`else
        lat = 3 + (31 - p);
`endif
        rem = 0;
        inc = 1'b0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            shift = p - 23;
            q     = mag >> shift;
            rem   = mag - (q << shift);
            half  = longint'(1) << (shift - 1);
            if (rem != 0) begin
                case (rmv)
                    3'b001:  inc = 1'b0;
                    3'b010:  inc = s;
                    3'b011:  inc = ~s;
                    3'b100:  inc = (rem >= half);
                    default: inc = (rem > half) || (rem == half && q[0]);
                endcase
            end
        end
        q = q + longint'(inc);
        if (q == 64'h100_0000) begin
            q = q >> 1;
            p++;
        end
        res = {s, 8'(p + 127), q[22:0]};
        nx  = (rem != 0);
    endfunction

    // Driver: issue one conversion, optionally pulse start again while busy.
    task automatic run_conv(input logic uns, input logic [2:0] rmv, input logic [31:0] x,
                            input bit pulse_busy,
                            output logic [31:0] res, output logic nx, output int lat,
                            output logic [31:0] res_after, output logic done_after);
        int k;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.int_in      = x;
        bus.is_unsigned = uns;
        bus.rm          = rmv;
        @(posedge clk);
        k   = 0;
        lat = -1;
        res = 32'hxxxx_xxxx;
        nx  = 1'bx;
        while (k < 60 && lat < 0) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                lat = k;
                res = bus.result;
                nx  = bus.inexact;
            end
            if (pulse_busy && k == 1) begin
                bus.int_in      = 32'h0001_2345;
                bus.is_unsigned = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        done_after = bus.done;
        @(negedge clk);
        res_after  = bus.result;
    endtask

    task automatic do_vector(input string tag, input logic uns, input logic [2:0] rmv,
                             input logic [31:0] x, input logic [31:0] e_res, input logic e_nx,
                             input bit pulse_busy);
        logic [31:0] res, res_after;
        logic        nx, done_after;
        int          lat, e_lat;
        logic [31:0] m_res;
        logic        m_nx;
        ref_model(uns, rmv, x, m_res, m_nx, e_lat);
        run_conv(uns, rmv, x, pulse_busy, res, nx, lat, res_after, done_after);
        check({tag, " result"}, res, e_res);
        check({tag, " inexact"}, {31'd0, nx}, {31'd0, e_nx});
        check({tag, " latency"}, 32'(lat), 32'(e_lat));
        check({tag, " done width"}, {31'd0, done_after}, 32'd0);
        check({tag, " result held"}, res_after, e_res);
    endtask

    initial begin
        vec_t        vecs[12];
        logic [31:0] m_res;
        logic        m_nx;
        int          m_lat;
        int          extra_done;
        logic [32:0] e;
        logic [31:0] res, res_after, x;
        logic        nx, done_after, uns;
        logic [2:0]  rmv;
        int          lat;

        n_tests = 0;
        n_fail  = 0;
        bus.start = 1'b0; bus.int_in = '0; bus.is_unsigned = 1'b0; bus.rm = 3'd0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset inexact", {31'd0, bus.inexact}, 32'd0);
        check("reset state", {30'd0, state_dbg}, {30'd0, S_IDLE});
        rst = 1'b0;

        vecs[0]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 32'h8000_0000, 32'hCF00_0000, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
        vecs[4]  = '{1'b0, 3'b001, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1};
        vecs[5]  = '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1};
        vecs[6]  = '{1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 3'b000, 32'h0100_0001, 32'h4B80_0000, 1'b1};
        vecs[8]  = '{1'b1, 3'b011, 32'h0100_0001, 32'h4B80_0001, 1'b1};
        vecs[9]  = '{1'b0, 3'b010, 32'hFEFF_FFFF, 32'hCB80_0001, 1'b1};
        vecs[10] = '{1'b1, 3'b111, 32'h0100_0003, 32'h4B80_0002, 1'b1};
        vecs[11] = '{1'b1, 3'b100, 32'h0100_0001, 32'h4B80_0001, 1'b1};

        for (int i = 0; i < 12; i++) begin
            do_vector($sformatf("vec%0d", i), vecs[i].uns, vecs[i].rmv, vecs[i].x,
                      vecs[i].exp_res, vecs[i].exp_nx, 1'b0);
        end

        // start pulsed while busy must not disturb the first conversion
        do_vector("busy_ignore", 1'b1, 3'b000, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b1);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("busy_ignore no second done", 32'(extra_done), 32'd0);

        // reset while in NORM discards the operation
        @(negedge clk);
        bus.start = 1'b1; bus.int_in = 32'h0000_0001; bus.is_unsigned = 1'b1; bus.rm = 3'd0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("rst_norm state before", {30'd0, state_dbg}, {30'd0, S_NORM});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_norm busy", {31'd0, bus.busy}, 32'd0);
        check("rst_norm result", bus.result, 32'd0);
        check("rst_norm inexact", {31'd0, bus.inexact}, 32'd0);
        extra_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check("rst_norm no done", 32'(extra_done), 32'd0);
        do_vector("after_rst", 1'b0, 3'b000, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 1'b0);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; bus.start = 1'b1; bus.int_in = 32'd5;
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_priority busy", {31'd0, bus.busy}, 32'd0);

        // Scoreboard: random conversions against the reference model
        for (int i = 0; i < 200; i++) begin
            uns = 1'($urandom_range(0, 1));
            rmv = 3'($urandom_range(0, 7));
            x   = $urandom() >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) x = ~x;
            ref_model(uns, rmv, x, m_res, m_nx, m_lat);
            exp_q.push_back({m_nx, m_res});
            run_conv(uns, rmv, x, 1'b0, res, nx, lat, res_after, done_after);
            e = exp_q.pop_front();
            check($sformatf("rand%0d x=%08h u=%0d rm=%0d result", i, x, uns, rmv), res, e[31:0]);
            check($sformatf("rand%0d inexact", i), {31'd0, nx}, {31'd0, e[32]});
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(m_lat));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
